serial_right_shifter: RTL and testbench
=======================================

Name: serial_right_shifter

Overview:
- Multi-cycle right shifter for the datapath shift library. It shifts one bit position per clock.
- Built without shift operators. Only bit-slicing and concatenation are allowed.
- It is the counterpart of the existing left-shift register.
- Operands arrive on a valid/ready input port. Results leave on a valid/ready output port. Logical and arithmetic modes are supported.

Parameters:
- WIDTH, 8: operand/result width in bits. Must be 2 or more.
- AMT_W, 4: width of the shift-amount field. Must satisfy 2^AMT_W > WIDTH so that over-range amounts are representable.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  operand.
- in_amt  input  AMT_W  shift amount.
- in_arith  input  1  fill mode: 1 = arithmetic (sign fill), 0 = logical (zero fill).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  shifted result.
- out_sticky  output  1  only present with RSHIFT_STICKY_EN. OR of all bits shifted out.

Behaviour:
- Interface decision: one clock, clk. Reset is synchronous and active-high, port reset.
- Reset values:
  - state = IDLE.
  - in_ready = 1 in the cycle after reset deasserts.
  - out_valid = 0, out_data = 0, out_sticky = 0.
  - Internal count = 0, fill = 0.
- States:
  - IDLE: in_ready = 1, out_valid = 0.
  - SHIFT: in_ready = 0, out_valid = 0.
  - DONE: in_ready = 0, out_valid = 1.
- Accept: in IDLE, an edge with in_valid = 1 does the following.
  - Load data_r = in_data.
  - fill = in_arith & in_data[WIDTH-1].
  - count = min(in_amt, WIDTH); amounts at or above WIDTH saturate to WIDTH.
  - Next state is DONE if count == 0, otherwise SHIFT.
- SHIFT, each edge:
  - data_r = {fill, data_r[WIDTH-1:1]}.
  - count decrements.
  - When count == 1 before the decrement, next state is DONE.
- Latency: out_valid rises k edges after the accept edge, where k = min(in_amt, WIDTH). With in_amt = 0, out_valid is high in the cycle immediately after acceptance.
- DONE:
  - out_data = data_r, held stable while out_valid = 1 and out_ready = 0.
  - An edge with out_ready = 1 moves to IDLE, so out_valid drops next cycle.
  - No bypass from DONE to accept in the same cycle. Throughput is one operand per k+2 cycles at best.
- Saturated amounts:
  - Logical mode gives result 0.
  - Arithmetic mode gives all bits equal to the original sign bit.
- Input behaviour:
  - in_data, in_amt and in_arith are sampled only on the accept edge.
  - Changes to them during SHIFT or DONE have no effect.
  - in_valid asserted outside IDLE is ignored (no acceptance).
- Reset mid-operation (SHIFT or DONE): the operation is aborted and nothing is emitted. The state returns to IDLE with all reset values the next cycle.
- Operator restriction: no >>, >>>, << or <<< anywhere in the RTL.

Optional Feature:
- Macro: RSHIFT_STICKY_EN.
- Defined:
  - out_sticky exists.
  - A sticky register clears on accept.
  - Each SHIFT edge ORs in data_r[0].
  - out_sticky is valid together with out_valid and is held in DONE.
  - For a saturated amount it is the OR of all original bits.
- Undefined: the port and register are absent; all other behaviour is identical.

Decomposition:
- Package srs_pkg holds:
  - state enum/localparams IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2.
  - default WIDTH/AMT_W constants.
- Optional sub-module srs_step_right: the combinational one-position right step. Inputs data and fill; outputs next data and shifted-out bit. The top instantiates it once.

Test Plan:
- Logical shift: in_data = 8'b1011_0110, amt = 3, arith = 0 -> out_data = 8'b0001_0110. out_valid rises exactly 3 edges after accept. Sticky (if enabled) = 1.
- Arithmetic shift: in_data = 8'b1001_0000, amt = 2, arith = 1 -> 8'b1110_0100, sticky = 0. Also in_data = 8'b0101_0000, amt = 2, arith = 1 -> 8'b0001_0100.
- Zero amount: in_data = 8'hA5, amt = 0 -> out_data = 8'hA5 in the cycle after accept, sticky = 0.
- Saturated amount: amt = 15 -> arith = 0 with 8'hFF gives 8'h00. arith = 1 with 8'h80 gives 8'hFF after 8 shift edges.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE -> out_data/out_valid stable and in_ready = 0. Raising out_ready gives in_ready = 1 the next cycle. in_valid pulses during SHIFT are not accepted.
- Reset during SHIFT (amt = 6, reset on 2nd shift edge) -> out_valid never asserts and in_ready = 1 after reset. A fresh operand after reset completes correctly.

Source files
------------

// File: rtl/srs_pkg.sv
// srs_pkg: shared state encoding and default sizes for serial_right_shifter
package srs_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } srs_state_t;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_AMT_W = 4;
endpackage

// File: rtl/srs_step_right.sv
// srs_step_right: one-position right step with a fill bit, exposing the bit that falls off
module srs_step_right #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             fill,
    output logic [WIDTH-1:0] next_data,
    output logic             shifted_out
);
    assign next_data   = {fill, data[WIDTH-1:1]};
    assign shifted_out = data[0];
endmodule

// File: rtl/serial_right_shifter.sv
// serial_right_shifter: one-bit-per-clock logical/arithmetic right shifter with valid/ready ports
// Define RSHIFT_STICKY_EN to add out_sticky, the OR of every bit shifted out.
module serial_right_shifter
    import srs_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = DEF_AMT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef RSHIFT_STICKY_EN
    ,
    output logic             out_sticky
`endif
);
    srs_state_t       state_q, state_d;
    logic [WIDTH-1:0] data_r, step_next;
    logic [AMT_W-1:0] count, amt_sat;
    logic             fill;
    logic             accept;
    assign amt_sat   = (in_amt >= AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : in_amt;
    assign accept    = (state_q == IDLE) && in_valid;
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign out_data  = data_r;
    always_comb begin
        state_d = (state_q == IDLE)  ? (in_valid ? ((amt_sat == '0) ? DONE : SHIFT) : IDLE) :
                  (state_q == SHIFT) ? ((count == AMT_W'(1)) ? DONE : SHIFT) :
                  (out_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end
`ifdef RSHIFT_STICKY_EN
    logic lost;
    srs_step_right #(.WIDTH(WIDTH)) u_step (
        .data(data_r), .fill(fill), .next_data(step_next), .shifted_out(lost)
    );
    always_ff @(posedge clk) begin
        if (reset)                 out_sticky <= 1'b0;
        else if (accept)           out_sticky <= 1'b0;
        else if (state_q == SHIFT) out_sticky <= out_sticky | lost;
    end
`else
    srs_step_right #(.WIDTH(WIDTH)) u_step (
        .data(data_r), .fill(fill), .next_data(step_next), .shifted_out()
    );
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r <= '0;
            fill   <= 1'b0;
            count  <= '0;
        end else if (accept) begin
            data_r <= in_data;
            fill   <= in_arith & in_data[WIDTH-1];
            count  <= amt_sat;
        end else if (state_q == SHIFT) begin
            data_r <= step_next;
            count  <= count - AMT_W'(1);
        end
    end
endmodule

// File: tb/tb_serial_right_shifter.sv
// tb_serial_right_shifter: directed + random stimulus against an arithmetic reference model
module tb_serial_right_shifter;
    localparam int W = 8;
    localparam int A = 4;
    logic         clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_arith = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic [A-1:0] in_amt = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] out_data;
    logic         sticky;
    int           vectors = 0, errors = 0;
    logic         m_init = 1'b0, m_ready = 1'b0, m_valid = 1'b0, m_stk = 1'b0;
    logic [W-1:0] m_res = '0;
    int           m_wait = 0;
    int           k;

    serial_right_shifter #(.WIDTH(W), .AMT_W(A)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_arith(in_arith),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef RSHIFT_STICKY_EN
        , .out_sticky(sticky)
`endif
    );
`ifndef RSHIFT_STICKY_EN
    assign sticky = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string nm, input int unsigned act, input int unsigned exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Right shift as division by 2^k; negative arithmetic values use floor division via complement.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int kk, input logic ar);
        logic [W-1:0] nd, q;
        int unsigned  p;
        if (kk >= W) return (ar && d[W-1]) ? '1 : '0;
        p = 32'd1;
        for (int i = 0; i < kk; i++) p = p * 2;
        nd = ~d;
        if (ar && d[W-1]) begin
            q = W'(32'(nd) / p);
            return ~q;
        end
        q = W'(32'(d) / p);
        return q;
    endfunction

    function automatic logic ref_sticky(input logic [W-1:0] d, input int kk);
        int unsigned p;
        if (kk >= W) return |d;
        p = 32'd1;
        for (int i = 0; i < kk; i++) p = p * 2;
        return (32'(d) % p) != 0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_init  <= 1'b1;
            m_ready <= 1'b1;
            m_valid <= 1'b0;
            m_wait  <= 0;
        end else if (m_ready && in_valid) begin
            k = (int'(in_amt) >= W) ? W : int'(in_amt);
            m_res   <= ref_shift(in_data, k, in_arith);
            m_stk   <= ref_sticky(in_data, k);
            m_ready <= 1'b0;
            m_valid <= (k == 0);
            m_wait  <= k;
        end else if (!m_ready && !m_valid) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) m_valid <= 1'b1;
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
            m_ready <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("in_ready", 32'(in_ready), 32'(m_ready));
            check("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                check("out_data", 32'(out_data), 32'(m_res));
`ifdef RSHIFT_STICKY_EN
                check("out_sticky", 32'(sticky), 32'(m_stk));
`endif
            end
        end
    end

    task automatic do_op(input logic [W-1:0] d, input logic [A-1:0] a, input logic ar,
                         input logic [W-1:0] exp, input logic es, input int hold, input int lat);
        int  n;
        bit  seen;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_amt = a; in_arith = ar; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
            else begin
                in_valid = 1'($urandom); in_data = W'($urandom);
                in_amt = A'($urandom); in_arith = 1'($urandom);
                @(posedge clk);
                #1 in_valid = 1'b0;
                n++;
            end
        end
        check("seen_valid", 32'(seen), 32'd1);
        check("latency", 32'(n), 32'(lat));
        check("lit_data", 32'(out_data), 32'(exp));
`ifdef RSHIFT_STICKY_EN
        check("lit_sticky", 32'(sticky), 32'(es));
`else
        if (es === 1'bx) check("lit_sticky", 32'(sticky), 32'd0);
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(exp));
            check("hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("release_ready", 32'(in_ready), 32'd1);
        check("release_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_sticky", 32'(sticky), 32'd0);
        do_op(8'b1011_0110, 4'd3, 1'b0, 8'b0001_0110, 1'b1, 0, 3);
        do_op(8'b1001_0000, 4'd2, 1'b1, 8'b1110_0100, 1'b0, 0, 2);
        do_op(8'b0101_0000, 4'd2, 1'b1, 8'b0001_0100, 1'b0, 0, 2);
        do_op(8'hA5, 4'd0, 1'b0, 8'hA5, 1'b0, 0, 0);
        do_op(8'hFF, 4'd15, 1'b0, 8'h00, 1'b1, 0, 8);
        do_op(8'h80, 4'd15, 1'b1, 8'hFF, 1'b1, 0, 8);
        do_op(8'h3C, 4'd1, 1'b0, 8'h1E, 1'b0, 5, 1);
        do_op(8'hC3, 4'd8, 1'b1, 8'hFF, 1'b1, 2, 8);
        // abort: reset is sampled on the second shift edge
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hF0; in_amt = 4'd6; in_arith = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(in_ready), 32'd1);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_data", 32'(out_data), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_quiet", 32'(out_valid), 32'd0);
        end
        do_op(8'hF0, 4'd6, 1'b0, 8'h03, 1'b1, 0, 6);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom);
            in_data   = W'($urandom);
            in_amt    = A'($urandom);
            in_arith  = 1'($urandom);
            out_ready = 1'($urandom);
            reset     = ($urandom_range(299, 0) == 0);
        end
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
